tx_medida_serial: RTL and testbench

//  Downstream of the HC-SR04 interface. On each pronto pulse from the interface
//  (driven on enviar), captures the 3-digit BCD distance and sends it over an

---
 rtl/tx_medida_serial.sv | 154 +++++++++++++++
 tb/tb_tx_medida_serial.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_medida_serial.sv
// tx_medida_serial: sends a latched 3-digit BCD distance as four 7E1 ASCII
// characters (hundreds, tens, units, '#') on an asynchronous serial line.
//
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous, active-high
//   enviar        start request (pulse or level), sampled only when idle
//   medida[11:0]  BCD distance: [11:8] hundreds, [7:4] tens, [3:0] units
//   saida_serial  serial TX line, idle high
//   ocupado       high while a message is in progress
//   pronto        one-cycle pulse when the message is complete
//   db_estado     current FSM state code
module tx_medida_serial #(
    parameter int unsigned CICLOS_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enviar,
    input  logic [11:0] medida,
    output logic        saida_serial,
    output logic        ocupado,
    output logic        pronto,
    output logic [3:0]  db_estado
);

    localparam int unsigned TICK_W   = (CICLOS_BIT > 2) ? $clog2(CICLOS_BIT) : 1;
    localparam int unsigned FRAME_W  = 10;
    localparam int unsigned BITC_W   = 4;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned MEDIDA_W = 12;

    typedef enum logic [3:0] {
        INICIAL   = 4'h0,
        PREPARA   = 4'h1,
        TRANSMITE = 4'h2,
        PROXIMO   = 4'h3,
        FINAL     = 4'hF
    } estado_t;

    estado_t               state_q, state_d;
    logic [MEDIDA_W-1:0]   medida_q, medida_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FRAME_W-1:0]    shreg_q, shreg_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BITC_W-1:0]     bitcnt_q, bitcnt_d;
    logic                  saida_q, saida_d;
    logic                  ocupado_q, ocupado_d;
    logic                  pronto_q, pronto_d;

    // Build a 10-bit frame, transmitted LSB first: start, d0..d6, even parity, stop.
    function automatic logic [FRAME_W-1:0] char_frame(input logic [IDX_W-1:0]    idx,
                                                      input logic [MEDIDA_W-1:0] m);
        logic [6:0] c;
        case (idx)
            2'd0:    c = 7'h30 + {3'b000, m[11:8]};
            2'd1:    c = 7'h30 + {3'b000, m[7:4]};
            2'd2:    c = 7'h30 + {3'b000, m[3:0]};
            default: c = 7'h23;
        endcase
        return {1'b1, ^c, c, 1'b0};
    endfunction

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d  = state_q;
        medida_d = medida_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        tick_d   = tick_q;
        bitcnt_d = bitcnt_q;

        case (state_q)
            INICIAL: begin
                if (enviar) begin
                    medida_d = medida;
                    state_d  = PREPARA;
                end
            end
            PREPARA: begin
                idx_d    = '0;
                shreg_d  = char_frame(2'd0, medida_q);
                tick_d   = '0;
                bitcnt_d = '0;
                state_d  = TRANSMITE;
            end
            TRANSMITE: begin
                if (tick_q == TICK_W'(CICLOS_BIT - 1)) begin
                    tick_d = '0;
                    if (bitcnt_q == BITC_W'(FRAME_W - 1)) begin
                        state_d = PROXIMO;
                    end else begin
                        bitcnt_d = bitcnt_q + BITC_W'(1);
                        shreg_d  = {1'b1, shreg_q[FRAME_W-1:1]};
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            PROXIMO: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(3)) begin
                    state_d = FINAL;
                end else begin
                    shreg_d  = char_frame(idx_q + IDX_W'(1), medida_q);
                    tick_d   = '0;
                    bitcnt_d = '0;
                    state_d  = TRANSMITE;
                end
            end
            FINAL: begin
                state_d = INICIAL;
            end
            default: begin
                state_d = INICIAL;
            end
        endcase

        // Outputs follow the state being entered so they are valid in that state's cycle.
        saida_d   = (state_d == TRANSMITE) ? shreg_d[0] : 1'b1;
        ocupado_d = (state_d != INICIAL);
        pronto_d  = (state_d == FINAL);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= INICIAL;
            medida_q  <= '0;
            idx_q     <= '0;
            shreg_q   <= '1;
            tick_q    <= '0;
            bitcnt_q  <= '0;
            saida_q   <= 1'b1;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            medida_q  <= medida_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            tick_q    <= tick_d;
            bitcnt_q  <= bitcnt_d;
            saida_q   <= saida_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
        end
    end

    assign saida_serial = saida_q;
    assign ocupado      = ocupado_q;
    assign pronto       = pronto_q;
    assign db_estado    = state_q;

endmodule

// File: tb/tb_tx_medida_serial.sv
// Bench for tx_medida_serial with CICLOS_BIT=4. Expected frames and pronto
// cycles are queued when stimulus is issued; independent monitors decode the
// serial line and watch pronto, popping and comparing.
module tb_tx_medida_serial;

    localparam int unsigned CB = 4;

    // Hand-computed frames, first transmitted bit leftmost.
    localparam logic [9:0] F_31 = 10'b0100011011;
    localparam logic [9:0] F_32 = 10'b0010011011;
    localparam logic [9:0] F_33 = 10'b0110011001;
    localparam logic [9:0] F_23 = 10'b0110001011;
    localparam logic [9:0] F_30 = 10'b0000011001;
    localparam logic [9:0] F_3A = 10'b0010111001;
    localparam logic [9:0] F_35 = 10'b0101011001;

    logic        clock = 1'b0;
    logic        reset;
    logic        enviar;
    logic [11:0] medida;
    logic        saida_serial;
    logic        ocupado;
    logic        pronto;
    logic [3:0]  db_estado;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    logic [9:0]  exp_frames[$];
    int unsigned exp_pronto[$];

    tx_medida_serial #(.CICLOS_BIT(CB)) dut (
        .clock        (clock),
        .reset        (reset),
        .enviar       (enviar),
        .medida       (medida),
        .saida_serial (saida_serial),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_msg(input logic [9:0] f0, input logic [9:0] f1,
                            input logic [9:0] f2, input logic [9:0] f3);
        exp_frames.push_back(f0);
        exp_frames.push_back(f1);
        exp_frames.push_back(f2);
        exp_frames.push_back(f3);
    endtask

    // Serial-line monitor: decodes each frame and checks each bit is held CB cycles.
    initial begin : rx_monitor
        logic       line_prev;
        logic [9:0] frame;
        logic       stable;
        logic       aborted;
        line_prev = 1'b1;
        forever begin
            @(negedge clock);
            if (reset === 1'b1) begin
                line_prev = 1'b1;
            end else if (line_prev && saida_serial === 1'b0) begin
                frame   = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int s = 0; s < CB && !aborted; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clock);
                        if (reset === 1'b1) aborted = 1'b1;
                        else if (s == 0) frame = {frame[8:0], saida_serial};
                        else if (saida_serial !== frame[0]) stable = 1'b0;
                    end
                end
                if (aborted) begin
                    line_prev = 1'b1;
                end else begin
                    if (exp_frames.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %b expected none (cycle %0d)", frame, cyc);
                    end else begin
                        check("frame", 32'(frame), 32'(exp_frames.pop_front()));
                    end
                    check("bit_hold", 32'(stable), 32'd1);
                    line_prev = saida_serial;
                end
            end else begin
                line_prev = saida_serial;
            end
        end
    end

    // pronto monitor: each pulse must land on the queued cycle.
    initial begin : pronto_monitor
        forever begin
            @(negedge clock);
            if (pronto === 1'b1) begin
                if (exp_pronto.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pronto: got pulse expected none (cycle %0d)", cyc);
                end else begin
                    check("pronto_cycle", cyc, exp_pronto.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int unsigned c0;
        int          high_cnt;
        reset  = 1'b1;
        enviar = 1'b0;
        medida = '0;
        step(2);
        check("rst_saida", 32'(saida_serial), 32'd1);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_pronto", 32'(pronto), 32'd0);
        check("rst_estado", 32'(db_estado), 32'd0);
        reset = 1'b0;
        step(1);

        // Basic message 123 with start-bit latency checks.
        medida = 12'h123;
        push_msg(F_31, F_32, F_33, F_23);
        exp_pronto.push_back(cyc + 166);
        enviar = 1'b1;
        step(1);
        enviar = 1'b0;
        check("prepara_saida", 32'(saida_serial), 32'd1);
        check("prepara_ocupado", 32'(ocupado), 32'd1);
        check("prepara_estado", 32'(db_estado), 32'd1);
        step(1);
        check("start_saida", 32'(saida_serial), 32'd0);
        check("transmite_estado", 32'(db_estado), 32'd2);
        step(200);
        check("idle_ocupado", 32'(ocupado), 32'd0);

        // medida changed mid-message is ignored.
        medida = 12'h123;
        push_msg(F_31, F_32, F_33, F_23);
        exp_pronto.push_back(cyc + 166);
        enviar = 1'b1;
        step(1);
        enviar = 1'b0;
        step(50);
        medida = 12'h999;
        step(150);

        // Extra enviar during char 2 is ignored; line stays idle afterwards.
        medida = 12'h123;
        push_msg(F_31, F_32, F_33, F_23);
        exp_pronto.push_back(cyc + 166);
        enviar = 1'b1;
        step(1);
        enviar = 1'b0;
        step(100);
        enviar = 1'b1;
        step(1);
        enviar = 1'b0;
        step(100);
        high_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (saida_serial === 1'b1) high_cnt++;
        end
        check("idle_line", 32'(high_cnt), 32'd20);

        // Reset during the tens char aborts; then message 0A5.
        medida = 12'h123;
        exp_frames.push_back(F_31);
        enviar = 1'b1;
        step(1);
        enviar = 1'b0;
        step(60);
        reset = 1'b1;
        step(1);
        check("abort_saida", 32'(saida_serial), 32'd1);
        check("abort_ocupado", 32'(ocupado), 32'd0);
        check("abort_pronto", 32'(pronto), 32'd0);
        check("abort_estado", 32'(db_estado), 32'd0);
        exp_frames.delete();
        exp_pronto.delete();
        reset = 1'b0;
        step(2);
        medida = 12'h0A5;
        push_msg(F_30, F_3A, F_35, F_23);
        exp_pronto.push_back(cyc + 166);
        enviar = 1'b1;
        step(1);
        enviar = 1'b0;
        medida = 12'h000;
        step(200);

        // enviar held high: two back-to-back messages, one idle cycle apart.
        medida = 12'h123;
        push_msg(F_31, F_32, F_33, F_23);
        push_msg(F_31, F_32, F_33, F_23);
        c0 = cyc;
        exp_pronto.push_back(c0 + 166);
        exp_pronto.push_back(c0 + 333);
        enviar = 1'b1;
        step(333);
        enviar = 1'b0;
        step(30);
        check("final_ocupado", 32'(ocupado), 32'd0);

        check("frames_left", 32'(exp_frames.size()), 32'd0);
        check("pronto_left", 32'(exp_pronto.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
